// File: rtl/complex_triple_loader.sv
// Operand sequencer for the 3-input complex adder: packs three streamed samples into
// slots a/b/c, presents them, then captures the adder's sum and overflow flag.
module complex_triple_loader #(
    parameter int unsigned QI = 4,
    parameter int unsigned QF = 4,
    parameter int unsigned CW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QI+QF-1:0] in_Re,
    input  logic [QI+QF-1:0] in_Im,

    output logic [QI+QF-1:0] a_Re,
    output logic [QI+QF-1:0] a_Im,
    output logic [QI+QF-1:0] b_Re,
    output logic [QI+QF-1:0] b_Im,
    output logic [QI+QF-1:0] c_Re,
    output logic [QI+QF-1:0] c_Im,
    output logic             out_valid,
    input  logic             out_ready,

    input  logic [QI+QF-1:0] res_Re,
    input  logic [QI+QF-1:0] res_Im,
    input  logic             res_overflow,

    output logic [QI+QF-1:0] sum_Re,
    output logic [QI+QF-1:0] sum_Im,
    output logic             sum_overflow,
    output logic             sum_valid,
    output logic [CW-1:0]    ovf_count
);

    localparam int unsigned W = QI + QF;

    typedef enum logic [0:0] {StFill, StPresent} state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;

    logic [W-1:0]  a_re_q, a_im_q;
    logic [W-1:0]  b_re_q, b_im_q;
    logic [W-1:0]  c_re_q, c_im_q;

    logic [W-1:0]  sum_re_q, sum_im_q;
    logic          sum_ovf_q;
    logic          sum_valid_q, sum_valid_d;
    logic [CW-1:0] ovf_q, ovf_d;

    logic          wr_a, wr_b, wr_c;
    logic          capture;

    // Handshake outputs are pure functions of the state, so there is no bubble
    // between the third accept and out_valid.
    assign in_ready  = (state_q == StFill);
    assign out_valid = (state_q == StPresent);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_c    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StFill: begin
                // flush wins over a same-cycle accept: the sample is dropped.
                if (flush) begin
                    idx_d = 2'd0;
                end else if (in_valid) begin
                    unique case (idx_q)
                        2'd0:    wr_a = 1'b1;
                        2'd1:    wr_b = 1'b1;
                        default: wr_c = 1'b1;
                    endcase
                    if (idx_q == 2'd2) begin
                        state_d = StPresent;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StPresent: begin
                if (out_ready) begin
                    capture = 1'b1;
                    state_d = StFill;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = StFill;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        sum_valid_d = capture;
        ovf_d       = ovf_q;
        if (capture && res_overflow && (ovf_q != {CW{1'b1}})) begin
            ovf_d = ovf_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Slots hold their values across triplets until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
            c_re_q <= '0;
            c_im_q <= '0;
        end else begin
            if (wr_a) begin
                a_re_q <= in_Re;
                a_im_q <= in_Im;
            end
            if (wr_b) begin
                b_re_q <= in_Re;
                b_im_q <= in_Im;
            end
            if (wr_c) begin
                c_re_q <= in_Re;
                c_im_q <= in_Im;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_re_q    <= '0;
            sum_im_q    <= '0;
            sum_ovf_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            sum_valid_q <= sum_valid_d;
            ovf_q       <= ovf_d;
            if (capture) begin
                sum_re_q  <= res_Re;
                sum_im_q  <= res_Im;
                sum_ovf_q <= res_overflow;
            end
        end
    end

    assign a_Re         = a_re_q;
    assign a_Im         = a_im_q;
    assign b_Re         = b_re_q;
    assign b_Im         = b_im_q;
    assign c_Re         = c_re_q;
    assign c_Im         = c_im_q;
    assign sum_Re       = sum_re_q;
    assign sum_Im       = sum_im_q;
    assign sum_overflow = sum_ovf_q;
    assign sum_valid    = sum_valid_q;
    assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_complex_triple_loader.sv
// Scoreboard bench for complex_triple_loader: a cycle model queues expected triplets and
// sums, directed phases pin down the listed scenarios, then a random stream soaks it.
module tb_complex_triple_loader;

    localparam int unsigned QI = 4;
    localparam int unsigned QF = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned W  = QI + QF;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_Re, in_Im;
    logic [W-1:0] a_Re, a_Im, b_Re, b_Im, c_Re, c_Im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res_Re, res_Im;
    logic         res_overflow;
    logic [W-1:0] sum_Re, sum_Im;
    logic         sum_overflow;
    logic         sum_valid;
    logic [CW-1:0] ovf_count;

    complex_triple_loader #(.QI(QI), .QF(QF), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_Re        (in_Re),
        .in_Im        (in_Im),
        .a_Re         (a_Re),
        .a_Im         (a_Im),
        .b_Re         (b_Re),
        .b_Im         (b_Im),
        .c_Re         (c_Re),
        .c_Im         (c_Im),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .res_Re       (res_Re),
        .res_Im       (res_Im),
        .res_overflow (res_overflow),
        .sum_Re       (sum_Re),
        .sum_Im       (sum_Im),
        .sum_overflow (sum_overflow),
        .sum_valid    (sum_valid),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state, advanced on every falling edge.
    logic [2*W-1:0] m_slot [3];
    int             m_idx     = 0;
    bit             m_present = 0;
    int             m_ovf     = 0;
    bit             exp_sv    = 0;
    int             n_acc     = 0;
    bit             ovf_force = 0;
    logic [6*W-1:0] trip_q [$];
    logic [2*W:0]   sum_q  [$];

    always @(negedge clk) begin
        logic [6*W-1:0] t;
        logic [2*W:0]   s;
        if (rst) begin
            m_idx     = 0;
            m_present = 0;
            m_ovf     = 0;
            exp_sv    = 0;
            trip_q.delete();
            sum_q.delete();
        end else begin
            check_eq("in_ready", in_ready, !m_present);
            check_eq("out_valid", out_valid, m_present);
            check_eq("sum_valid", sum_valid, exp_sv);
            check_eq("ovf_count", ovf_count, m_ovf);
            if (sum_valid) begin
                if (sum_q.size() == 0) begin
                    check_eq("sum_unexpected", 1, 0);
                end else begin
                    s = sum_q.pop_front();
                    check_eq("sum", {sum_Re, sum_Im, sum_overflow}, s);
                end
            end
            exp_sv = 0;
            if (!m_present) begin
                if (flush) begin
                    m_idx = 0;
                end else if (in_valid) begin
                    m_slot[m_idx] = {in_Re, in_Im};
                    n_acc++;
                    if (m_idx == 2) begin
                        m_idx     = 0;
                        m_present = 1;
                        trip_q.push_back({m_slot[0], m_slot[1], m_slot[2]});
                    end else begin
                        m_idx++;
                    end
                end
            end else if (out_ready) begin
                if (trip_q.size() == 0) begin
                    check_eq("trip_underflow", 1, 0);
                end else begin
                    t = trip_q.pop_front();
                    check_eq("slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, t);
                end
                sum_q.push_back({res_Re, res_Im, res_overflow});
                if (res_overflow && m_ovf != 3) m_ovf++;
                exp_sv    = 1;
                m_present = 0;
            end
            // Behave as the adder: drive the modulo sum of the pending triplet.
            if (m_present && trip_q.size() > 0) begin
                t      = trip_q[0];
                res_Re = t[6*W-1:5*W] + t[4*W-1:3*W] + t[2*W-1:W];
                res_Im = t[5*W-1:4*W] + t[3*W-1:2*W] + t[W-1:0];
            end
            res_overflow = ovf_force;
        end
    end

    task automatic feed(input logic [W-1:0] re, input logic [W-1:0] im);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_Re    = re;
        in_Im    = im;
        acc      = 0;
        n        = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("feed_timeout", 0, 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_Re        = '0;
        in_Im        = '0;
        out_ready    = 1'b0;
        res_Re       = '0;
        res_Im       = '0;
        res_overflow = 1'b0;

        // Reset state
        repeat (2) next_cycle();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sum_valid", sum_valid, 0);
        check_eq("rst_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 0);
        check_eq("rst_sum", {sum_Re, sum_Im, sum_overflow, ovf_count}, 0);
        rst = 1'b0;
        next_cycle();
        check_eq("rst_in_ready", in_ready, 1);

        // 1: back-to-back triplet, consumer always ready
        out_ready = 1'b1;
        feed(8'h12, 8'h03);
        feed(8'h01, 8'h06);
        feed(8'h04, 8'h03);
        in_valid = 1'b0;
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 48'h12_03_01_06_04_03);
        next_cycle();
        check_eq("t1_sum_valid", sum_valid, 1);
        check_eq("t1_sum", {sum_Re, sum_Im}, 16'h170C);
        check_eq("t1_ovf_count", ovf_count, 0);

        // 2: back-pressure, flush during PRESENT is ignored
        out_ready = 1'b0;
        feed(8'hFD, 8'hFE);
        feed(8'h01, 8'h01);
        feed(8'hFF, 8'hFF);
        in_Re = 8'h55;
        in_Im = 8'h66;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            @(negedge clk);
            check_eq("t2_hold_valid", out_valid, 1);
            check_eq("t2_hold_ready", in_ready, 0);
            check_eq("t2_hold_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 48'hFD_FE_01_01_FF_FF);
            next_cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        next_cycle();
        check_eq("t2_sum_valid", sum_valid, 1);
        check_eq("t2_sum", {sum_Re, sum_Im}, 16'hFDFE);
        next_cycle();
        check_eq("t2_single_pulse", sum_valid, 0);

        // 3: flush a partial triplet, with a sample offered in the flush cycle
        feed(8'h31, 8'h32);
        feed(8'h33, 8'h34);
        in_Re = 8'h77;
        in_Im = 8'h77;
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        feed(8'h00, 8'h00);
        feed(8'h00, 8'h00);
        feed(8'h00, 8'h00);
        in_valid = 1'b0;
        check_eq("t3_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 0);
        next_cycle();
        check_eq("t3_sum_valid", sum_valid, 1);
        check_eq("t3_sum", {sum_Re, sum_Im}, 0);

        // 4: overflow counter saturates at 2^CW-1
        ovf_force = 1;
        for (int k = 0; k < 4; k++) begin
            feed(8'(k), 8'h01);
            feed(8'h02, 8'h02);
            feed(8'h03, 8'h03);
            in_valid = 1'b0;
            next_cycle();
            check_eq("t4_sum_ovf", sum_overflow, 1);
            check_eq("t4_ovf_count", ovf_count, (k < 3) ? k + 1 : 3);
        end
        ovf_force = 0;

        // 5: reset mid-triplet
        feed(8'h41, 8'h42);
        feed(8'h43, 8'h44);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("t5_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 0);
        check_eq("t5_sum", {sum_Re, sum_Im, sum_overflow, ovf_count}, 0);
        check_eq("t5_flags", {out_valid, sum_valid}, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check_eq("t5_no_pulse", sum_valid, 0);
        feed(8'h21, 8'h22);
        feed(8'h23, 8'h24);
        feed(8'h25, 8'h26);
        in_valid = 1'b0;
        check_eq("t5_fresh_slots", {a_Re, a_Im, b_Re, b_Im, c_Re, c_Im}, 48'h21_22_23_24_25_26);
        next_cycle();

        // 6: random valid/ready soak, 30 samples
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 30 && cyc < 2000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_Re     = 8'($urandom);
            in_Im     = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready && n_acc == 29) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                next_cycle();
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) next_cycle();
        check_eq("t6_samples", n_acc, 30);
        check_eq("t6_trip_drained", trip_q.size(), 0);
        check_eq("t6_sum_drained", sum_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
